game_core: RTL and testbench
============================

Name: game_core

Overview:
- Parametrised successor to the single-player game logic block.
- Runs the game-mode FSM, signed-velocity player physics paced by a frame tick, and inclusive-overlap collision against N_OBS obstacle slots.
- Adds lives with post-hit invulnerability, a pass-score counter and a hit pulse.
- Sits between the obstacle generator (which drives the coordinates) and the renderer/HUD (which consume gamemode, player_y, lives and score).

Parameters:
- N_OBS, 10, number of obstacle slots
- XW, 10, obstacle x coordinate width
- YW, 9, y coordinate width (player and obstacles)
- UPPER_BOUND, 20, minimum player_y
- LOWER_BOUND, 460, maximum player_y + PLAYER_SIZE
- PLAYER_SIZE, 40, player square edge in pixels
- PLAYER_X, 160, fixed player left x
- START_Y, 220, player_y after reset or return to IDLE
- MAX_VEL, 8, velocity magnitude limit in px/frame
- ACCEL, 1, velocity change per frame
- LIVES, 3, starting lives (must be at least 1)
- INVULN_FRAMES, 60, frames of hit immunity after a hit
- SCORE_W, 16, score width

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle strobe per video frame; all physics, collision and scoring advance only on it
- sw  in  3  sw[0]=flap held; sw[2:1]=mode request
- obstacle_valid  in  N_OBS  slot occupied
- obstacle_x  in  N_OBS*2*XW  slot k: [k*2XW +: XW]=left, next XW=right
- obstacle_y  in  N_OBS*2*YW  slot k: [k*2YW +: YW]=top, next YW=bottom
- gamemode  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER (registered)
- player_y  out  YW  player top y
- lives  out  $clog2(LIVES+1)  remaining lives
- score  out  SCORE_W  obstacles passed, saturating
- hit_pulse  out  1  one-cycle pulse on each life lost

Behaviour:
- Reset (rst_n=0 at a clk edge): gamemode=00, player_y=START_Y, velocity=0, lives=LIVES, score=0, invuln=0, hit_pulse=0, all passed flags cleared.
- FSM, evaluated every clk, not gated by the tick:
  - any state + sw[2:1]=00 -> IDLE, with the same reinitialisation as reset.
  - IDLE + 01 -> PLAY.
  - PLAY + 10 -> PAUSE; PAUSE + 01 -> PLAY.
  - PLAY -> OVER when lives becomes 0. OVER is sticky; only sw[2:1]=00 leaves it.
  - sw[2:1]=11 is ignored in every state.
- Physics, on frame_tick in PLAY only:
  - Velocity is signed, range [-MAX_VEL, +MAX_VEL]; positive means down.
  - Flap: v = max(v-ACCEL, -MAX_VEL). No flap: v = min(v+ACCEL, +MAX_VEL).
  - y_next = player_y + v_next, computed with at least YW+2 signed bits.
  - Clamp y_next to [UPPER_BOUND, LOWER_BOUND-PLAYER_SIZE]. When clamping occurs, v is set to 0.
  - Result is registered at the tick edge, so latency is 1 clk.
- PAUSE/OVER: player_y, velocity, score, lives and invuln all hold. Ticks are ignored.
- Collision, on tick in PLAY, using pre-update player_y. Slot k hits when all of:
  - valid
  - left <= PLAYER_X+PLAYER_SIZE
  - right >= PLAYER_X
  - top <= player_y+PLAYER_SIZE
  - bottom >= player_y
  - Bounds are inclusive. Multiple simultaneous slot hits count as one hit.
- Hit with invuln=0: lives-1, invuln=INVULN_FRAMES, hit_pulse=1 for exactly that cycle. If lives reaches 0, gamemode=11 on the next cycle.
- Hit with invuln>0: ignored.
- Invulnerability countdown: invuln decrements by 1 on each PLAY tick while nonzero.
- Scoring, on tick in PLAY:
  - Slot k passes when valid and right < PLAYER_X and its passed flag is clear; the flag is then set.
  - The flag clears when the slot goes invalid or right >= PLAYER_X, in any mode.
  - score += popcount(new passes), saturating at 2^SCORE_W-1.
  - Scoring happens on the same tick as any collision; a hit does not block scoring.
- Width rule: all geometry comparisons are done unsigned at max(XW,YW)+1 bits, so no wrap occurs.

Decomposition:
- Shared package game_pkg:
  - mode encodings MODE_IDLE/PLAY/PAUSE/OVER
  - default geometry constants
  - helper function for obstacle field slicing
- One sub-module: game_hit_unit, a combinational per-slot overlap and pass-detect, instantiated N_OBS times via generate. The FSM, physics and counters stay in game_core.

Test Plan:
- Reset/idle: rst_n low, then sw=000, 5 ticks -> gamemode=00, player_y=220, lives=3, score=0, hit_pulse never asserted.
- Fall and clamp: sw[2:1]=01, no flap, 30 ticks, no valid obstacles -> v climbs 1..8, player_y follows the cumulative sum, then stops at exactly 420 with v=0. Same with flap held -> stops at 20.
- Pause hold: in PLAY at y=250, set sw[2:1]=10 and give 10 ticks -> y, v and score unchanged. Return to 01 -> motion resumes from the same v.
- Collision/invuln: slot 0 x=[150,170], y=[0,479] held for 100 ticks, INVULN_FRAMES=60 -> hit_pulse on tick 1 and tick 62, lives 3->2->1.
- Game over: repeat the collision scenario until lives=0 -> gamemode=11 one clk later. sw[2:1]=01 keeps OVER; sw[2:1]=00 -> IDLE, lives=3.
- Scoring: slots 2 and 5 both move right from 160 to 150 on the same tick -> score +2 once. A slot held at right=150 for more ticks adds nothing. Preload score=65535 -> stays 65535.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game core slice.
//   - mode_t      : game-mode encodings shared by core, renderer and HUD
//   - DEF_*       : default geometry and gameplay constants
//   - fieldLsb()  : bit offset of one coordinate inside a packed obstacle bus
package game_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_PLAY  = 2'b01,
    MODE_PAUSE = 2'b10,
    MODE_OVER  = 2'b11
  } mode_t;

  localparam int DEF_N_OBS         = 10;
  localparam int DEF_XW            = 10;
  localparam int DEF_YW            = 9;
  localparam int DEF_UPPER_BOUND   = 20;
  localparam int DEF_LOWER_BOUND   = 460;
  localparam int DEF_PLAYER_SIZE   = 40;
  localparam int DEF_PLAYER_X      = 160;
  localparam int DEF_START_Y       = 220;
  localparam int DEF_MAX_VEL       = 8;
  localparam int DEF_ACCEL         = 1;
  localparam int DEF_LIVES         = 3;
  localparam int DEF_INVULN_FRAMES = 60;
  localparam int DEF_SCORE_W       = 16;

  // Each obstacle slot owns two adjacent fields of 'width' bits:
  // upper=0 selects the low field (left / top), upper=1 the high one
  // (right / bottom).
  function automatic int fieldLsb(input int slot, input int width, input int upper);
    return slot * 2 * width + upper * width;
  endfunction

endpackage

// File: rtl/game_if.sv
// game_if: bundle of everything between obstacle generator / HUD and the core.
//   i_frame_tick     : one-cycle strobe per video frame
//   i_sw             : sw[0] flap, sw[2:1] mode request
//   i_obstacle_valid : one bit per obstacle slot
//   i_obstacle_x/_y  : packed left/right and top/bottom per slot
//   o_gamemode       : registered game mode
//   o_player_y       : player top y
//   o_lives/o_score  : HUD counters
//   o_hit_pulse      : one-cycle pulse per life lost
// master = environment side (drives i_*), slave = game_core.
interface game_if #(
  parameter int N_OBS   = 10,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int LW      = 2,
  parameter int SCORE_W = 16
);
  logic                    i_frame_tick;
  logic [2:0]              i_sw;
  logic [N_OBS-1:0]        i_obstacle_valid;
  logic [N_OBS*2*XW-1:0]   i_obstacle_x;
  logic [N_OBS*2*YW-1:0]   i_obstacle_y;
  logic [1:0]              o_gamemode;
  logic [YW-1:0]           o_player_y;
  logic [LW-1:0]           o_lives;
  logic [SCORE_W-1:0]      o_score;
  logic                    o_hit_pulse;

  modport master (
    output i_frame_tick, i_sw, i_obstacle_valid, i_obstacle_x, i_obstacle_y,
    input  o_gamemode, o_player_y, o_lives, o_score, o_hit_pulse
  );

  modport slave (
    input  i_frame_tick, i_sw, i_obstacle_valid, i_obstacle_x, i_obstacle_y,
    output o_gamemode, o_player_y, o_lives, o_score, o_hit_pulse
  );
endinterface

// File: rtl/game_hit_unit.sv
// game_hit_unit: combinational per-slot collision and pass detection.
//   i_valid            : slot occupied
//   i_left/i_right     : obstacle x span
//   i_top/i_bottom     : obstacle y span
//   i_playerY          : player top y before this frame's update
//   i_passed           : slot already counted as passed
//   o_hit              : inclusive overlap with the player square
//   o_newPass          : slot is fully left of the player and not yet counted
//   o_clearPass        : slot no longer qualifies, so its passed flag drops
module game_hit_unit #(
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int PLAYER_X    = 160,
  parameter int PLAYER_SIZE = 40
) (
  input  logic          i_valid,
  input  logic [XW-1:0] i_left,
  input  logic [XW-1:0] i_right,
  input  logic [YW-1:0] i_top,
  input  logic [YW-1:0] i_bottom,
  input  logic [YW-1:0] i_playerY,
  input  logic          i_passed,
  output logic          o_hit,
  output logic          o_newPass,
  output logic          o_clearPass
);
  // One extra bit over the wider coordinate so player_y + size cannot wrap.
  localparam int CW = ((XW > YW) ? XW : YW) + 1;

  localparam logic [CW-1:0] C_PX_L = CW'(PLAYER_X);
  localparam logic [CW-1:0] C_PX_R = CW'(PLAYER_X + PLAYER_SIZE);

  logic [CW-1:0] w_left, w_right, w_top, w_bottom, w_pyTop, w_pyBot;

  assign w_left   = CW'(i_left);
  assign w_right  = CW'(i_right);
  assign w_top    = CW'(i_top);
  assign w_bottom = CW'(i_bottom);
  assign w_pyTop  = CW'(i_playerY);
  assign w_pyBot  = CW'(i_playerY) + CW'(PLAYER_SIZE);

  assign o_hit = i_valid && (w_left <= C_PX_R) && (w_right >= C_PX_L) &&
                 (w_top <= w_pyBot) && (w_bottom >= w_pyTop);

  assign o_newPass   = i_valid && (w_right < C_PX_L) && !i_passed;
  assign o_clearPass = !i_valid || (w_right >= C_PX_L);
endmodule

// File: rtl/game_core.sv
// game_core: game-mode FSM, frame-paced player physics, lives/invulnerability
// and pass scoring against N_OBS obstacle slots.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : game_if slave (frame tick, switches, obstacles in; mode, player_y,
//           lives, score, hit pulse out)
module game_core
  import game_pkg::*;
#(
  parameter int N_OBS         = DEF_N_OBS,
  parameter int XW            = DEF_XW,
  parameter int YW            = DEF_YW,
  parameter int UPPER_BOUND   = DEF_UPPER_BOUND,
  parameter int LOWER_BOUND   = DEF_LOWER_BOUND,
  parameter int PLAYER_SIZE   = DEF_PLAYER_SIZE,
  parameter int PLAYER_X      = DEF_PLAYER_X,
  parameter int START_Y       = DEF_START_Y,
  parameter int MAX_VEL       = DEF_MAX_VEL,
  parameter int ACCEL         = DEF_ACCEL,
  parameter int LIVES         = DEF_LIVES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int SCORE_W       = DEF_SCORE_W
) (
  input logic   clk,
  input logic   rst_n,
  game_if.slave bus
);
  localparam int LW = $clog2(LIVES + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 1);
  localparam int VW = $clog2(MAX_VEL + 1) + 1;
  localparam int SW = YW + 2;
  localparam int PW = $clog2(N_OBS + 1);
  localparam int AW = ((SCORE_W + 1) > (PW + 1)) ? (SCORE_W + 1) : (PW + 1);

  localparam logic signed [SW-1:0] C_ACCEL = SW'(ACCEL);
  localparam logic signed [SW-1:0] C_MAXV  = SW'(MAX_VEL);
  localparam logic signed [SW-1:0] C_YMIN  = SW'(UPPER_BOUND);
  localparam logic signed [SW-1:0] C_YMAX  = SW'(LOWER_BOUND - PLAYER_SIZE);
  localparam logic [AW-1:0]        C_SMAX  = AW'({SCORE_W{1'b1}});

  mode_t               r_mode, w_modeNext;
  logic [YW-1:0]       r_playerY, w_yNext;
  logic signed [VW-1:0] r_vel;
  logic [LW-1:0]       r_lives;
  logic [SCORE_W-1:0]  r_score;
  logic [IW-1:0]       r_invuln;
  logic [N_OBS-1:0]    r_passed;
  logic                r_hitPulse;

  logic [N_OBS-1:0]    w_hit, w_newPass, w_clearPass;
  logic                w_reinit, w_playTick, w_takeHit;
  logic [PW-1:0]       w_passCount;
  logic [AW-1:0]       w_scoreSum;
  logic signed [SW-1:0] w_velCur, w_velNext, w_velStore, w_ySum;

  genvar k;
  generate
    for (k = 0; k < N_OBS; k++) begin : g_slot
      game_hit_unit #(
        .XW(XW), .YW(YW), .PLAYER_X(PLAYER_X), .PLAYER_SIZE(PLAYER_SIZE)
      ) u_hit (
        .i_valid    (bus.i_obstacle_valid[k]),
        .i_left     (bus.i_obstacle_x[fieldLsb(k, XW, 0) +: XW]),
        .i_right    (bus.i_obstacle_x[fieldLsb(k, XW, 1) +: XW]),
        .i_top      (bus.i_obstacle_y[fieldLsb(k, YW, 0) +: YW]),
        .i_bottom   (bus.i_obstacle_y[fieldLsb(k, YW, 1) +: YW]),
        .i_playerY  (r_playerY),
        .i_passed   (r_passed[k]),
        .o_hit      (w_hit[k]),
        .o_newPass  (w_newPass[k]),
        .o_clearPass(w_clearPass[k])
      );
    end
  endgenerate

  assign w_reinit   = (bus.i_sw[2:1] == 2'b00);
  assign w_playTick = bus.i_frame_tick && (r_mode == MODE_PLAY);
  // A hit only costs a life outside the immunity window; guarding on
  // nonzero lives keeps the counter from wrapping in the one cycle
  // between the last life going and the FSM reaching OVER.
  assign w_takeHit  = w_playTick && (|w_hit) && (r_invuln == '0) && (r_lives != '0);

  // Mode state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_mode <= MODE_IDLE;
    else        r_mode <= w_modeNext;
  end

  // Mode transitions run every clock; request 11 falls through to a hold.
  always_comb begin
    w_modeNext = r_mode;
    if (w_reinit) begin
      w_modeNext = MODE_IDLE;
    end else begin
      case (r_mode)
        MODE_IDLE:  if (bus.i_sw[2:1] == 2'b01) w_modeNext = MODE_PLAY;
        MODE_PLAY:  if (r_lives == '0) w_modeNext = MODE_OVER;
                    else if (bus.i_sw[2:1] == 2'b10) w_modeNext = MODE_PAUSE;
        MODE_PAUSE: if (bus.i_sw[2:1] == 2'b01) w_modeNext = MODE_PLAY;
        default:    w_modeNext = MODE_OVER;
      endcase
    end
  end

  // Velocity step, then position with a clamp that also kills the velocity.
  always_comb begin
    w_velCur = SW'(r_vel);
    if (bus.i_sw[0]) w_velNext = ((w_velCur - C_ACCEL) < -C_MAXV) ? -C_MAXV : (w_velCur - C_ACCEL);
    else             w_velNext = ((w_velCur + C_ACCEL) > C_MAXV) ? C_MAXV : (w_velCur + C_ACCEL);
    w_ySum     = $signed({2'b00, r_playerY}) + w_velNext;
    w_yNext    = w_ySum[YW-1:0];
    w_velStore = w_velNext;
    if (w_ySum < C_YMIN) begin
      w_yNext    = YW'(UPPER_BOUND);
      w_velStore = '0;
    end else if (w_ySum > C_YMAX) begin
      w_yNext    = YW'(LOWER_BOUND - PLAYER_SIZE);
      w_velStore = '0;
    end
  end

  // Number of slots newly passed this frame, added to the score with saturation.
  always_comb begin
    w_passCount = '0;
    for (int i = 0; i < N_OBS; i++) w_passCount = w_passCount + PW'(w_newPass[i]);
    w_scoreSum = AW'(r_score) + AW'(w_passCount);
    if (w_scoreSum > C_SMAX) w_scoreSum = C_SMAX;
  end

  // Gameplay state. Everything but the passed flags only moves on a PLAY tick,
  // so PAUSE and OVER freeze the game for free.
  always_ff @(posedge clk) begin
    if (!rst_n || w_reinit) begin
      r_playerY  <= YW'(START_Y);
      r_vel      <= '0;
      r_lives    <= LW'(LIVES);
      r_score    <= '0;
      r_invuln   <= '0;
      r_passed   <= '0;
      r_hitPulse <= 1'b0;
    end else begin
      r_hitPulse <= w_takeHit;
      r_passed   <= (r_passed | (w_newPass & {N_OBS{w_playTick}})) & ~w_clearPass;
      if (w_playTick) begin
        r_playerY <= w_yNext;
        r_vel     <= VW'(w_velStore);
        r_score   <= w_scoreSum[SCORE_W-1:0];
        if (w_takeHit) begin
          r_lives  <= r_lives - LW'(1);
          r_invuln <= IW'(INVULN_FRAMES);
        end else if (r_invuln != '0) begin
          r_invuln <= r_invuln - IW'(1);
        end
      end
    end
  end

  assign bus.o_gamemode  = r_mode;
  assign bus.o_player_y  = r_playerY;
  assign bus.o_lives     = r_lives;
  assign bus.o_score     = r_score;
  assign bus.o_hit_pulse = r_hitPulse;
endmodule

// File: tb/tb_game_core.sv
// tb_game_core: directed bench for game_core. A frame-level behavioural model
// (plain integers) predicts every output each cycle; a few literal values pin
// the model at the interesting points. A second core with a 2-bit score
// exercises score saturation.
module tb_game_core;
  localparam int N       = 10;
  localparam int PX      = 160;
  localparam int PSIZE   = 40;
  localparam int YMIN    = 20;
  localparam int YMAX    = 420;
  localparam int VMAX    = 8;
  localparam int INV     = 60;
  localparam int SMAX    = 65535;
  localparam int SMAX2   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic [2:0] sw = 3'b000;

  bit obsV [N];
  int obsL [N];
  int obsR [N];
  int obsT [N];
  int obsB [N];

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;
  int pulses [$];

  // Model state
  int mMode = 0, mY = 220, mV = 0, mLives = 3, mInv = 0;
  int mScore = 0, mScore2 = 0, mHitPulse = 0;
  bit mPassed [N];

  game_if #(.N_OBS(N), .XW(10), .YW(9), .LW(2), .SCORE_W(16)) bus ();
  game_if #(.N_OBS(N), .XW(10), .YW(9), .LW(2), .SCORE_W(2))  bus2 ();

  game_core dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  game_core #(.SCORE_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  assign bus.i_frame_tick      = tick;
  assign bus.i_sw              = sw;
  assign bus2.i_frame_tick     = tick;
  assign bus2.i_sw             = sw;
  assign bus2.i_obstacle_valid = bus.i_obstacle_valid;
  assign bus2.i_obstacle_x     = bus.i_obstacle_x;
  assign bus2.i_obstacle_y     = bus.i_obstacle_y;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic packObstacles();
    for (int k = 0; k < N; k++) begin
      bus.i_obstacle_valid[k]          = obsV[k];
      bus.i_obstacle_x[k*20 +: 10]     = 10'(obsL[k]);
      bus.i_obstacle_x[k*20+10 +: 10]  = 10'(obsR[k]);
      bus.i_obstacle_y[k*18 +: 9]      = 9'(obsT[k]);
      bus.i_obstacle_y[k*18+9 +: 9]    = 9'(obsB[k]);
    end
  endtask

  task automatic setSlot(input int k, input bit v, input int l, input int r, input int t, input int b);
    obsV[k] = v; obsL[k] = l; obsR[k] = r; obsT[k] = t; obsB[k] = b;
    packObstacles();
  endtask

  // Apply a switch setting, let the mode settle, then issue nTicks frame
  // ticks spaced four clocks apart, logging which tick produced a hit pulse.
  task automatic applyStimulus(input logic [2:0] swVal, input int nTicks);
    pulses.delete();
    @(negedge clk); sw = swVal;
    repeat (2) @(negedge clk);
    for (int t = 1; t <= nTicks; t++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (bus.o_hit_pulse) pulses.push_back(t);
      repeat (3) @(negedge clk);
    end
  endtask

  // Frame-level model: what a frame in PLAY does to the game, from the rules.
  always @(posedge clk) begin : modelStep
    int y, v, nPass, nextMode;
    bit hit, pt, take;
    bit np [N];
    if (!rst_n || sw[2:1] == 2'b00) begin
      mMode <= 0; mY <= 220; mV <= 0; mLives <= 3; mInv <= 0;
      mScore <= 0; mScore2 <= 0; mHitPulse <= 0;
      for (int k = 0; k < N; k++) mPassed[k] <= 1'b0;
    end else begin
      pt = tick && (mMode == 1);
      hit = 1'b0; nPass = 0;
      for (int k = 0; k < N; k++) begin
        if (obsV[k] && obsL[k] <= PX + PSIZE && obsR[k] >= PX &&
            obsT[k] <= mY + PSIZE && obsB[k] >= mY) hit = 1'b1;
        np[k] = mPassed[k];
        if (!obsV[k] || obsR[k] >= PX) np[k] = 1'b0;
        else if (pt && !mPassed[k]) begin np[k] = 1'b1; nPass++; end
        mPassed[k] <= np[k];
      end
      take = pt && hit && mInv == 0 && mLives > 0;
      mHitPulse <= take ? 1 : 0;
      if (pt) begin
        v = sw[0] ? ((mV - 1 < -VMAX) ? -VMAX : mV - 1) : ((mV + 1 > VMAX) ? VMAX : mV + 1);
        y = mY + v;
        if (y < YMIN) begin y = YMIN; v = 0; end
        else if (y > YMAX) begin y = YMAX; v = 0; end
        mY <= y; mV <= v;
        mScore  <= (mScore + nPass > SMAX) ? SMAX : mScore + nPass;
        mScore2 <= (mScore2 + nPass > SMAX2) ? SMAX2 : mScore2 + nPass;
        if (take) begin mLives <= mLives - 1; mInv <= INV; end
        else if (mInv > 0) mInv <= mInv - 1;
      end
      nextMode = mMode;
      if (mMode == 0 && sw[2:1] == 2'b01) nextMode = 1;
      else if (mMode == 1 && mLives == 0) nextMode = 3;
      else if (mMode == 1 && sw[2:1] == 2'b10) nextMode = 2;
      else if (mMode == 2 && sw[2:1] == 2'b01) nextMode = 1;
      mMode <= nextMode;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cycMode",  int'(bus.o_gamemode),  mMode);
      checkOutput("cycY",     int'(bus.o_player_y),  mY);
      checkOutput("cycLives", int'(bus.o_lives),     mLives);
      checkOutput("cycScore", int'(bus.o_score),     mScore);
      checkOutput("cycPulse", int'(bus.o_hit_pulse), mHitPulse);
      checkOutput("cycScore2", int'(bus2.o_score),   mScore2);
    end
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      obsV[k] = 1'b0; obsL[k] = 0; obsR[k] = 0; obsT[k] = 0; obsB[k] = 0;
    end
    packObstacles();
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("resetMode",  int'(bus.o_gamemode), 0);
    checkOutput("resetY",     int'(bus.o_player_y), 220);
    checkOutput("resetLives", int'(bus.o_lives), 3);
    checkOutput("resetScore", int'(bus.o_score), 0);
    rst_n = 1'b1;

    // Idle: ticks do nothing
    applyStimulus(3'b000, 5);
    checkOutput("idleMode",    int'(bus.o_gamemode), 0);
    checkOutput("idleY",       int'(bus.o_player_y), 220);
    checkOutput("idleNoPulse", pulses.size(), 0);

    // Fall to the lower clamp, then flap to the upper clamp
    applyStimulus(3'b010, 30);
    checkOutput("fallMode", int'(bus.o_gamemode), 1);
    checkOutput("fallY",    int'(bus.o_player_y), 420);
    applyStimulus(3'b011, 60);
    checkOutput("flapY",    int'(bus.o_player_y), 20);

    // From y=20, v=0: 21,23,26,30,35 then pause holds, resume gives v=6
    applyStimulus(3'b010, 5);
    checkOutput("prePauseY", int'(bus.o_player_y), 35);
    applyStimulus(3'b100, 10);
    checkOutput("pauseMode", int'(bus.o_gamemode), 2);
    checkOutput("pauseY",    int'(bus.o_player_y), 35);
    applyStimulus(3'b010, 1);
    checkOutput("resumeY",   int'(bus.o_player_y), 41);

    // Collision with a full-height obstacle across the player column
    applyStimulus(3'b000, 0);
    setSlot(0, 1'b1, 150, 170, 0, 479);
    applyStimulus(3'b010, 100);
    checkOutput("hitCount", pulses.size(), 2);
    if (pulses.size() == 2) begin
      checkOutput("hitTick1", pulses[0], 1);
      checkOutput("hitTick2", pulses[1], 62);
    end
    checkOutput("hitLives", int'(bus.o_lives), 1);

    // Third hit lands on tick 123 overall (tick 23 here)
    applyStimulus(3'b010, 25);
    checkOutput("overPulseCnt", pulses.size(), 1);
    if (pulses.size() == 1) checkOutput("overPulseTick", pulses[0], 23);
    checkOutput("overLives", int'(bus.o_lives), 0);
    checkOutput("overMode",  int'(bus.o_gamemode), 3);
    applyStimulus(3'b010, 3);
    checkOutput("overSticky", int'(bus.o_gamemode), 3);
    applyStimulus(3'b000, 0);
    checkOutput("backIdle",   int'(bus.o_gamemode), 0);
    checkOutput("backLives",  int'(bus.o_lives), 3);

    // Scoring: slots 2 and 5 cross to the left of the player together
    setSlot(0, 1'b0, 0, 0, 0, 0);
    setSlot(2, 1'b1, 140, 160, 0, 10);
    setSlot(5, 1'b1, 140, 160, 0, 10);
    applyStimulus(3'b010, 1);
    checkOutput("scoreEdge", int'(bus.o_score), 0);
    setSlot(2, 1'b1, 130, 150, 0, 10);
    setSlot(5, 1'b1, 130, 150, 0, 10);
    applyStimulus(3'b010, 1);
    checkOutput("scorePass", int'(bus.o_score), 2);
    applyStimulus(3'b010, 3);
    checkOutput("scoreHold", int'(bus.o_score), 2);
    checkOutput("scoreNoHit", int'(bus.o_lives), 3);

    // Re-arm the flags and pass again: 16-bit score 4, 2-bit score saturates
    setSlot(2, 1'b1, 140, 160, 0, 10);
    setSlot(5, 1'b1, 140, 160, 0, 10);
    applyStimulus(3'b010, 1);
    setSlot(2, 1'b1, 130, 150, 0, 10);
    setSlot(5, 1'b1, 130, 150, 0, 10);
    applyStimulus(3'b010, 1);
    checkOutput("scoreAgain", int'(bus.o_score), 4);
    checkOutput("scoreSat",   int'(bus2.o_score), 3);

    repeat (2) @(negedge clk);
    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
